// File: rtl/buf_cnt_ctrl_pkg.sv
// buf_cnt_ctrl_pkg: shared state encoding and constants for the buf_cnt sequencer.
package buf_cnt_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} state_e;
  localparam int DEF_W = 8;
  localparam logic DEF_FILL = 1'b0;
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;
endpackage

// File: rtl/buf_cnt_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer moves only when a grant is issued.
module rr_arb2
  import buf_cnt_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic last_q, last_d;
  // On contention the requester not served last wins.
  assign gnt_o = !en_i ? 2'b00 : (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;
  assign last_d = gnt_o[REQ1] ? 1'b1 : gnt_o[REQ0] ? 1'b0 : last_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/buf_cnt_ctrl.sv
// buf_cnt_ctrl: arbitrated load/count/complete sequencer for one buf_cnt datapath.
// Define BUF_CNT_CTRL_TIMEOUT_EN to build the RUN timeout counter and ERR state.
module buf_cnt_ctrl
  import buf_cnt_ctrl_pkg::*;
#(
  parameter int   W       = DEF_W,
  parameter logic FILL    = DEF_FILL,
  parameter int   TIMEOUT = 300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  input  logic         co,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic         busy,
  output logic         ld,
  output logic         en_cnt,
  output logic         en_tri,
  output logic         SI,
  output logic [W-1:0] PI
);
  state_e state_q, state_d;
  logic [1:0] gnt_q, gnt_d, arb_gnt;
  logic [W-1:0] pi_q, pi_d;
  logic tmo;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q == IDLE),
    .req_i ({req1, req0}),
    .gnt_o (arb_gnt)
  );
`ifdef BUF_CNT_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = state_q == LOAD ? '0 : state_q == RUN ? cnt_q + 1'b1 : cnt_q;
  // Fires on the RUN edge where the count reaches TIMEOUT; co still wins.
  assign tmo = cnt_d == CW'(TIMEOUT);
  assign err = state_q == ERR;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    pi_d = pi_q;
    case (state_q)
      IDLE: if (|arb_gnt) begin
        state_d = LOAD;
        gnt_d = arb_gnt;
        pi_d = arb_gnt[REQ1] ? data1 : data0;
      end
      LOAD: state_d = RUN;
      RUN: state_d = co ? DONE : tmo ? ERR : RUN;
      default: begin
        state_d = IDLE;
        gnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      pi_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      pi_q <= pi_d;
    end
  assign gnt0 = gnt_q[REQ0];
  assign gnt1 = gnt_q[REQ1];
  assign done0 = gnt_q[REQ0] & (state_q == DONE || state_q == ERR);
  assign done1 = gnt_q[REQ1] & (state_q == DONE || state_q == ERR);
  assign busy = state_q != IDLE;
  assign ld = state_q == LOAD;
  assign en_cnt = state_q == RUN;
  assign en_tri = state_q == RUN;
  assign SI = (state_q == RUN) & FILL;
  assign PI = pi_q;
endmodule

// File: tb/tb_buf_cnt_ctrl.sv
// tb_buf_cnt_ctrl: directed scoreboard bench for buf_cnt_ctrl with a behavioural co source.
module tb_buf_cnt_ctrl;
  typedef struct {
    bit         idx;
    logic [7:0] data;
    int         run;
    bit         err;
  } exp_t;
  logic clk, rst, req0, req1, co, co_force;
  logic [7:0] data0, data1, PI;
  logic gnt0, gnt1, done0, done1, err, busy, ld, en_cnt, en_tri, SI;
  int co_delay, run_idx;
  int ncmp, nfail, run_len, done_cnt, err_seen;
  bit prev_busy;
  exp_t cur;
  exp_t sb[$];
  buf_cnt_ctrl #(.W(8), .FILL(1'b0), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .co(co), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .busy(busy), .ld(ld), .en_cnt(en_cnt), .en_tri(en_tri), .SI(SI), .PI(PI)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Datapath model: co rises in the co_delay-th RUN cycle (never if co_delay < 1).
  always @(posedge clk or posedge rst)
    if (rst) run_idx <= 0;
    else run_idx <= en_cnt ? run_idx + 1 : 0;
  assign co = co_force | (en_cnt && run_idx == co_delay - 1);

  function automatic logic [1:0] oh(bit idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (rst) begin
      prev_busy = 1'b0;
      return;
    end
    if (err) err_seen++;
    if (ld) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) cur = sb.pop_front();
      chk("ld_gnt", {gnt1, gnt0}, oh(cur.idx));
      chk("ld_pi", PI, cur.data);
      chk("ld_prev_idle", prev_busy, 0);
      chk("ld_tri_si", {en_tri, en_cnt, SI}, 0);
      run_len = 0;
    end
    if (en_cnt) begin
      run_len++;
      chk("run_tri_si", {en_tri, SI}, 2'b10);
    end
    if (done0 | done1) begin
      chk("done_vec", {done1, done0}, oh(cur.idx));
      chk("done_gnt", {gnt1, gnt0}, oh(cur.idx));
      chk("done_run_len", run_len, cur.run);
      chk("done_err", err, cur.err);
      done_cnt++;
    end
    prev_busy = busy;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
  endtask

  task automatic wait_idle(int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
  endtask

  task automatic loads(int n, int budget);
    int k = 0;
    for (int i = 0; i < budget && k < n; i++) begin
      tick();
      if (ld) k++;
    end
    chk("load_count", k, n);
  endtask

  initial begin
    int dc, exp_done, exp_err;
    ncmp = 0; nfail = 0; done_cnt = 0; err_seen = 0; run_len = 0; prev_busy = 0;
    cur = '{0, 8'h00, 0, 0};
    rst = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0; co_force = 0; co_delay = -1;
    repeat (2) @(negedge clk);
    chk("reset_outs", {gnt0, gnt1, done0, done1, err, busy, ld, en_cnt, en_tri, SI, PI}, 0);
    rst = 1'b0;
    tick();
    // single transfer from requester 0
    co_delay = 5; data0 = 8'h0A; req0 = 1;
    sb.push_back('{0, 8'h0A, 5, 0});
    tick();
    chk("t1_load_latency", ld, 1);
    req0 = 0;
    wait_idle(50);
    // requester 1 drops its request in the second RUN cycle
    co_delay = 4; data1 = 8'h33; req1 = 1;
    sb.push_back('{1, 8'h33, 4, 0});
    repeat (3) tick();
    chk("t3_run2", en_cnt, 1);
    req1 = 0;
    wait_idle(50);
    // contention: last served was 1, so 0,1,0,1
    co_delay = 2; data0 = 8'h11; data1 = 8'h22; req0 = 1; req1 = 1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{0, 8'h11, 2, 0});
      sb.push_back('{1, 8'h22, 2, 0});
    end
    loads(4, 100);
    req0 = 0; req1 = 0;
    wait_idle(50);
    // co held high everywhere: ignored in IDLE and LOAD, RUN lasts one cycle
    co_force = 1; co_delay = -1;
    repeat (2) tick();
    chk("t5_idle_co", busy, 0);
    data0 = 8'h44; req0 = 1;
    sb.push_back('{0, 8'h44, 1, 0});
    tick();
    req0 = 0;
    tick();
    chk("t5_load_not_short", {en_cnt, done0}, 2'b10);
    tick();
    chk("t5_done", done0, 1);
    wait_idle(20);
    co_force = 0;
    // asynchronous reset in the third RUN cycle
    co_delay = 10; data1 = 8'h55; req1 = 1;
    sb.push_back('{1, 8'h55, 10, 0});
    tick();
    req1 = 0;
    repeat (3) tick();
    chk("t4_run3", en_cnt, 1);
    dc = done_cnt;
    #2 rst = 1'b1;
    #1 chk("t4_async_outs", {gnt0, gnt1, done0, done1, err, busy, ld, en_cnt, en_tri, SI, PI}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t4_no_done", done_cnt, dc);
    co_delay = 2; data0 = 8'h66; data1 = 8'h77; req0 = 1; req1 = 1;
    sb.push_back('{0, 8'h66, 2, 0});
    sb.push_back('{1, 8'h77, 2, 0});
    loads(2, 50);
    req0 = 0; req1 = 0;
    wait_idle(50);
    // co never arrives
    co_delay = -1; data0 = 8'h88; req0 = 1;
`ifdef BUF_CNT_CTRL_TIMEOUT_EN
    sb.push_back('{0, 8'h88, 4, 1});
    tick();
    req0 = 0;
    wait_idle(50);
    exp_done = 10; exp_err = 1;
`else
    sb.push_back('{0, 8'h88, 0, 0});
    tick();
    req0 = 0;
    repeat (20) tick();
    chk("t6_still_busy", {busy, en_cnt}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    exp_done = 9; exp_err = 0;
`endif
    chk("sb_drained", sb.size(), 0);
    chk("err_pulses", err_seen, exp_err);
    chk("done_pulses", done_cnt, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
